// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned QDEPTH_DEFAULT = 2;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned NUM_REGS       = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: pipe/long-latency results, issue tracking, decode checks, regfile port.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_data;
  logic              mul_valid;
  logic              mul_ready;
  logic [REG_AW-1:0] mul_rd;
  logic [XLEN-1:0]   mul_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic [REG_AW-1:0] chk_a;
  logic [REG_AW-1:0] chk_b;
  logic              chk_a_pending;
  logic              chk_b_pending;
  logic              rf_load;
  logic [REG_AW-1:0] rf_dest;
  logic [XLEN-1:0]   rf_in;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mul_valid, mul_rd, mul_data,
    input  issue_valid, issue_rd, chk_a, chk_b,
    output mul_ready, chk_a_pending, chk_b_pending,
    output rf_load, rf_dest, rf_in
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mul_valid, mul_rd, mul_data,
    output issue_valid, issue_rd, chk_a, chk_b,
    input  mul_ready, chk_a_pending, chk_b_pending,
    input  rf_load, rf_dest, rf_in
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries; DEPTH must be a power of two so pointers wrap freely.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port owner: pipe results win, queued long-latency results fill idle slots,
// and a pending scoreboard lets decode stall on registers still awaiting a long result.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  logic                q_full, q_empty, q_push, q_pop;
  logic                pipe_wr, mul_accept, retire;
  wb_entry_t           q_head, q_in;

  logic                rf_load_q, rf_load_d;
  logic                rf_from_q_q, rf_from_q_d;
  logic [REG_AW-1:0]   rf_dest_q, rf_dest_d;
  logic [XLEN-1:0]     rf_in_q, rf_in_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign bus.mul_ready = ~q_full & ~rst;
  assign mul_accept    = bus.mul_valid & bus.mul_ready;
  // Results for x0 are handshaken but dropped.
  assign q_push        = mul_accept & (bus.mul_rd != '0);
  assign pipe_wr       = bus.pipe_valid & (bus.pipe_rd != '0);
  assign q_pop         = ~pipe_wr & ~q_empty;
  assign q_in          = '{rd: bus.mul_rd, data: bus.mul_data};

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_data_i (q_in),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    rf_load_d   = 1'b0;
    rf_from_q_d = 1'b0;
    rf_dest_d   = rf_dest_q;
    rf_in_d     = rf_in_q;
    if (pipe_wr) begin
      rf_load_d = 1'b1;
      rf_dest_d = bus.pipe_rd;
      rf_in_d   = bus.pipe_data;
    end else if (q_pop) begin
      rf_load_d   = 1'b1;
      rf_from_q_d = 1'b1;
      rf_dest_d   = q_head.rd;
      rf_in_d     = q_head.data;
    end
  end

  assign retire = rf_load_q & rf_from_q_q;

  // Clear on retire first so a same-cycle issue to that register re-arms it.
  always_comb begin
    pending_d = pending_q;
    if (retire) pending_d[rf_dest_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_load_q   <= 1'b0;
      rf_from_q_q <= 1'b0;
      rf_dest_q   <= '0;
      rf_in_q     <= '0;
      pending_q   <= '0;
    end else begin
      rf_load_q   <= rf_load_d;
      rf_from_q_q <= rf_from_q_d;
      rf_dest_q   <= rf_dest_d;
      rf_in_q     <= rf_in_d;
      pending_q   <= pending_d;
    end
  end

  // The retiring register reads as ready: the regfile write-through supplies it this cycle.
  assign bus.chk_a_pending = pending_q[bus.chk_a] & ~(retire & (rf_dest_q == bus.chk_a));
  assign bus.chk_b_pending = pending_q[bus.chk_b] & ~(retire & (rf_dest_q == bus.chk_b));

  assign bus.rf_load = rf_load_q;
  assign bus.rf_dest = rf_dest_q;
  assign bus.rf_in   = rf_in_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned QD = QDEPTH_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: result queue, pending set, and the regfile-port registers.
  wb_entry_t   mq[$];
  bit          mpend[32];
  bit          m_load, m_fromq;
  logic [4:0]  m_dest;
  logic [31:0] m_in;
  logic [4:0]  infl[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_eff(input logic [4:0] r);
    return mpend[r] && !(m_load && m_fromq && m_dest == r);
  endfunction

  task automatic model_update();
    bit        acc;
    wb_entry_t e;
    if (rst) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      m_load = 0; m_fromq = 0; m_dest = '0; m_in = '0;
    end else begin
      acc = bus.mul_valid && (mq.size() < QD);
      if (m_load && m_fromq) mpend[m_dest] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) mpend[bus.issue_rd] = 1'b1;
      if (bus.pipe_valid && bus.pipe_rd != 0) begin
        m_load = 1; m_fromq = 0; m_dest = bus.pipe_rd; m_in = bus.pipe_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_load = 1; m_fromq = 1; m_dest = e.rd; m_in = e.data;
      end else begin
        m_load = 0; m_fromq = 0;
      end
      if (acc && bus.mul_rd != 0) mq.push_back('{rd: bus.mul_rd, data: bus.mul_data});
    end
  endtask

  // One clock: check combinational outputs, advance, check registered outputs.
  task automatic step();
    #1;
    check("mul_ready", 32'(bus.mul_ready), 32'(!rst && mq.size() < QD));
    check("chk_a_pending", 32'(bus.chk_a_pending), 32'(m_eff(bus.chk_a)));
    check("chk_b_pending", 32'(bus.chk_b_pending), 32'(m_eff(bus.chk_b)));
    if (!rst && bus.issue_valid) assert (!m_eff(bus.issue_rd));
    @(posedge clk);
    #1;
    model_update();
    check("rf_load", 32'(bus.rf_load), 32'(m_load));
    check("rf_dest", 32'(bus.rf_dest), 32'(m_dest));
    check("rf_in", bus.rf_in, m_in);
  endtask

  task automatic idle();
    bus.pipe_valid = 0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.mul_valid = 0; bus.mul_rd = '0; bus.mul_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
    bus.chk_a = '0; bus.chk_b = '0;
  endtask

  task automatic issue(input logic [4:0] r);
    idle();
    bus.issue_valid = 1; bus.issue_rd = r;
    step();
  endtask

  initial begin
    int         idx;
    bit         acc_exp;
    bit         issued;
    logic [4:0] r;

    // Reset
    rst = 1; idle();
    @(posedge clk); #1; model_update();
    step();
    check("reset_load", 32'(bus.rf_load), 32'd0);
    check("reset_dest", 32'(bus.rf_dest), 32'd0);
    check("ready_in_rst", 32'(bus.mul_ready), 32'd0);
    rst = 0; #1;
    check("ready_after_rst", 32'(bus.mul_ready), 32'd1);

    // Pipe path, then x0 suppression
    bus.pipe_valid = 1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    step();
    check("pipe_load", 32'(bus.rf_load), 32'd1);
    check("pipe_dest", 32'(bus.rf_dest), 32'd5);
    check("pipe_data", bus.rf_in, 32'hDEADBEEF);
    bus.pipe_rd = 5'd0;
    step();
    check("pipe_x0_noload", 32'(bus.rf_load), 32'd0);

    // Issue rd7, long result two cycles after handshake
    issue(5'd7);
    idle(); bus.chk_a = 5'd7; #1;
    check("issue7_pending", 32'(bus.chk_a_pending), 32'd1);
    bus.mul_valid = 1; bus.mul_rd = 5'd7; bus.mul_data = 32'd42;
    step();
    bus.mul_valid = 0;
    step();
    check("mul7_load", 32'(bus.rf_load), 32'd1);
    check("mul7_dest", 32'(bus.rf_dest), 32'd7);
    check("mul7_data", bus.rf_in, 32'd42);
    #1 check("mul7_chk_clear", 32'(bus.chk_a_pending), 32'd0);
    step();
    check("mul7_chk_after", 32'(bus.chk_a_pending), 32'd0);

    // Starvation by pipe fills the queue; drain in order afterwards
    issue(5'd3);
    issue(5'd4);
    idle(); bus.pipe_valid = 1; bus.pipe_rd = 5'd10; bus.pipe_data = 32'h1010;
    bus.mul_valid = 1; bus.mul_rd = 5'd3; bus.mul_data = 32'h33;
    step();
    bus.mul_rd = 5'd4; bus.mul_data = 32'h44;
    step();
    bus.mul_valid = 0; #1;
    check("full_not_ready", 32'(bus.mul_ready), 32'd0);
    step(); step();
    bus.pipe_valid = 0;
    step();
    check("drain1_dest", 32'(bus.rf_dest), 32'd3);
    check("drain1_data", bus.rf_in, 32'h33);
    step();
    check("drain2_dest", 32'(bus.rf_dest), 32'd4);
    check("drain2_data", bus.rf_in, 32'h44);
    check("drain_ready", 32'(bus.mul_ready), 32'd1);
    step();

    // Re-issue rd9 in the cycle its earlier result retires: pending must stay set
    issue(5'd9);
    idle(); bus.mul_valid = 1; bus.mul_rd = 5'd9; bus.mul_data = 32'h99;
    step();
    idle();
    step();
    check("rd9_retire_dest", 32'(bus.rf_dest), 32'd9);
    bus.issue_valid = 1; bus.issue_rd = 5'd9; bus.chk_a = 5'd9;
    step();
    idle(); bus.chk_a = 5'd9; #1;
    check("set_wins", 32'(bus.chk_a_pending), 32'd1);

    // Reset with a full queue and pending rd3/rd4
    issue(5'd3);
    issue(5'd4);
    idle(); bus.pipe_valid = 1; bus.pipe_rd = 5'd12; bus.pipe_data = 32'h1212;
    bus.mul_valid = 1; bus.mul_rd = 5'd3; bus.mul_data = 32'h333;
    step();
    bus.mul_rd = 5'd4; bus.mul_data = 32'h444;
    step();
    idle(); rst = 1;
    step();
    check("rst_mid_load", 32'(bus.rf_load), 32'd0);
    check("rst_mid_ready", 32'(bus.mul_ready), 32'd0);
    rst = 0; bus.chk_a = 5'd3; bus.chk_b = 5'd4;
    repeat (4) step();
    check("rst_chk3", 32'(bus.chk_a_pending), 32'd0);
    check("rst_chk4", 32'(bus.chk_b_pending), 32'd0);
    bus.chk_a = 5'd9; #1;
    check("rst_chk9", 32'(bus.chk_a_pending), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.pipe_valid = 1'($urandom_range(0, 1));
      bus.pipe_rd    = 5'($urandom);
      bus.pipe_data  = $urandom;
      bus.chk_a      = 5'($urandom);
      bus.chk_b      = 5'($urandom);
      bus.issue_valid = 0; bus.issue_rd = '0; issued = 0;
      if (!rst && $urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(1, 31));
        if (!m_eff(r)) begin
          bus.issue_valid = 1; bus.issue_rd = r; issued = 1;
        end
      end
      bus.mul_valid = 0; bus.mul_rd = '0; bus.mul_data = $urandom; idx = -1;
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, infl.size() - 1);
        bus.mul_valid = 1; bus.mul_rd = infl[idx];
      end else if ($urandom_range(0, 9) == 0) begin
        bus.mul_valid = 1;
      end
      acc_exp = !rst && (mq.size() < QD);
      step();
      if (rst) infl.delete();
      else begin
        if (idx >= 0 && acc_exp) infl.delete(idx);
        if (issued) infl.push_back(r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and long-latency scoreboard that owns the single write port of the integer register file. It merges in-order MEM/WB results with out-of-band results from the multi-cycle multiply/divide unit and drives the regfile write port from registers. It also tracks which architectural registers await a long-latency result, so decode can stall on them.

## Interface
- QDEPTH, 2, entries in the long-latency result queue (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_valid  in  1  MEM/WB result valid; always accepted, no backpressure
- pipe_rd  in  5  MEM/WB destination
- pipe_data  in  32  MEM/WB result
- mul_valid  in  1  long-latency result valid
- mul_ready  out  1  queue can accept a long-latency result
- mul_rd  in  5  long-latency destination
- mul_data  in  32  long-latency result
- issue_valid  in  1  long-latency op dispatched this cycle
- issue_rd  in  5  its destination
- chk_a, chk_b  in  5  decode source registers to check
- chk_a_pending, chk_b_pending  out  1  source awaits a long-latency result
- rf_load  out  1  regfile write enable
- rf_dest  out  5  regfile write address
- rf_in  out  32  regfile write data

## Operation
- rf_load, rf_dest and rf_in are registered and update every posedge. Internal flag rf_from_q marks that the current write came from the queue.
- Pipe path: if pipe_valid and pipe_rd≠0, the next cycle has rf_load=1, rf_dest=pipe_rd, rf_in=pipe_data. This path always takes priority.
- Queue: a FIFO of QDEPTH {rd,data} entries.
  - mul_ready = (count < QDEPTH) and not rst.
  - An accepted result (mul_valid & mul_ready) with mul_rd≠0 is pushed. One with mul_rd=0 is consumed and discarded.
- Pop: when pipe_valid=0 (or pipe_rd=0) and the queue is non-empty, the head moves to the output registers and rf_from_q=1.
- If neither path writes, rf_load=0. rf_dest and rf_in hold their previous values.
- A push and a pop in the same cycle are legal. mul_ready depends only on the registered count, so a full queue stays not-ready even during a pop cycle.
- Scoreboard: 32 pending bits; bit 0 is never set.
  - Set at posedge when issue_valid and issue_rd≠0.
  - Cleared at the posedge that ends a cycle with rf_load & rf_from_q, for bit rf_dest.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- chk_x_pending = pending[chk_x] & ~(rf_load & rf_from_q & rf_dest==chk_x). This is combinational; the regfile's write-through supplies the value in that same cycle.
- Issuing a long op to an already-pending rd is illegal. The issue unit stalls instead; the bench asserts this never happens.
- Queue order equals completion order. Write-after-write between pipe and queue for the same rd is prevented upstream by the pending check.

## Timing
- Pipe result to rf_load: 1 cycle.
- Long-latency result accepted into an empty queue with the pipe idle: rf_load asserts 2 cycles after the handshake cycle.
- Queue starvation: sustained pipe_valid stalls pops indefinitely. Backpressure reaches the multiplier via mul_ready only.
- Reset (takes effect at the next posedge, including mid-operation):
  - Queue emptied, all pending bits cleared.
  - rf_load=0, rf_dest=0, rf_in=0, rf_from_q=0.
  - mul_ready=0 while rst is high; mul_ready=1 in the first cycle after.
  - Queued results are lost. The pipeline flushes alongside.

## Structure
- Package wb_pkg: wb_entry_t struct {logic [4:0] rd; logic [31:0] data;} and the default QDEPTH constant.
- Sub-module wb_fifo: parameterised circular buffer of wb_entry_t with wrapping pointers and a count register. It exposes push, pop, head, full and empty.
- Scoreboard and output registers live in wb_arbiter.

## Test plan
- Reset, then pipe_valid with rd=5 and data=0xDEADBEEF. Required: next cycle rf_load=1, rf_dest=5, rf_in=0xDEADBEEF. pipe rd=0 gives rf_load=0.
- Issue rd=7, then hold chk_a=7. Required: chk_a_pending=1 from the cycle after issue. Then a mul result rd=7, data=42 with the pipe idle. Required: rf_load=1, rf_dest=7 two cycles after the handshake; chk_a_pending=0 in that same cycle and after.
- Hold pipe_valid high and push 2 mul results (rd=3, rd=4). Required: mul_ready=0 after the 2nd push, no queue writes. Drop pipe_valid. Required: rd=3 then rd=4 written on consecutive cycles; mul_ready returns to 1.
- Same-cycle issue rd=9 while the queue writes rd=9 from an earlier op. Required: pending[9] remains 1.
- Queue full with pending rd=3 and rd=4, then assert rst for 1 cycle. Required: rf_load=0, mul_ready=0 during rst, all chk pending=0 afterwards, and no stale write ever appears.
